// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8-bit UART receiver with one parity bit and one stop bit.
//            Oversampled at 16x baud, mid-bit sampling, break detection.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter logic PARITYMODE = 1'b0,   // 0 = even, 1 = odd
    parameter int   OVERSAMPLE = 16      // clk cycles per bit
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dataout,
    output logic       rdsig,
    output logic       dataerror,
    output logic       frameerror,
    output logic       busy
);

    // START checks at the middle of the start bit; every later bit is then
    // sampled one full bit period on, which lands on its middle as well.
    localparam logic [3:0] c_MID_SAMPLE  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] c_LAST_SAMPLE = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_sync1;
    logic       r_sync2;
    logic       w_rxs;
    logic [3:0] r_cnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic       r_par_err;
    logic       w_cnt_clear;
    logic       w_take_data;
    logic       w_take_par;
    logic       w_take_stop;

    assign w_rxs = r_sync2;
    assign busy  = (r_state != IDLE);

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and sampling strobes.
    always_comb begin
        w_state_next = r_state;
        w_cnt_clear  = 1'b0;
        w_take_data  = 1'b0;
        w_take_par   = 1'b0;
        w_take_stop  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clear = 1'b1;
                if (!w_rxs) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (r_cnt == c_MID_SAMPLE) begin
                    w_cnt_clear  = 1'b1;
                    // A line back high at mid start bit was only a glitch.
                    w_state_next = w_rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == c_LAST_SAMPLE) begin
                    w_take_data = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (r_cnt == c_LAST_SAMPLE) begin
                    w_take_par   = 1'b1;
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (r_cnt == c_LAST_SAMPLE) begin
                    w_take_stop  = 1'b1;
                    // Returning to IDLE right away lets a back-to-back start
                    // bit be seen; a low stop bit means the line is in break.
                    w_state_next = w_rxs ? IDLE : BREAK;
                end
            end
            BREAK: begin
                w_cnt_clear = 1'b1;
                if (w_rxs) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_cnt_clear  = 1'b1;
                w_state_next = IDLE;
            end
        endcase
    end

    // Sample counter and data bit index; the counter wraps freely per bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 4'd0;
            r_bit_idx <= 3'd0;
        end else begin
            r_cnt <= w_cnt_clear ? 4'd0 : r_cnt + 4'd1;
            if (r_state != DATA) begin
                r_bit_idx <= 3'd0;
            end else if (w_take_data) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    // Byte assembly (LSB first) and parity evaluation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= 8'h00;
            r_par_err <= 1'b0;
        end else begin
            if (w_take_data) begin
                r_shift[r_bit_idx] <= w_rxs;
            end
            if (w_take_par) begin
                r_par_err <= w_rxs ^ (^r_shift) ^ PARITYMODE;
            end
        end
    end

    // Frame delivery: one-cycle rdsig with data and flags held until the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdsig      <= 1'b0;
            dataout    <= 8'h00;
            dataerror  <= 1'b0;
            frameerror <= 1'b0;
        end else begin
            rdsig <= w_take_stop;
            if (w_take_stop) begin
                dataout    <= r_shift;
                dataerror  <= r_par_err;
                frameerror <= ~w_rxs;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx (even- and odd-parity instances
//            share one serial line).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] dataout,    dataout_o;
    logic       rdsig,      rdsig_o;
    logic       dataerror,  dataerror_o;
    logic       frameerror, frameerror_o;
    logic       busy,       busy_o;

    uart_rx #(.PARITYMODE(1'b0), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .rx(rx), .dataout(dataout), .rdsig(rdsig),
        .dataerror(dataerror), .frameerror(frameerror), .busy(busy)
    );

    uart_rx #(.PARITYMODE(1'b1), .OVERSAMPLE(16)) dut_odd (
        .clk(clk), .rst(rst), .rx(rx), .dataout(dataout_o), .rdsig(rdsig_o),
        .dataerror(dataerror_o), .frameerror(frameerror_o), .busy(busy_o)
    );

    always #5 clk = ~clk;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int busy_cnt   = 0;
    int pulses_odd = 0;
    int n_exp      = 0;
    int stop_edge  = 0;

    typedef struct {
        int         c;
        logic [7:0] d;
        logic       de;
        logic       fe;
        logic [7:0] d_o;
        logic       de_o;
        logic       fe_o;
    } rec_t;

    typedef struct {
        logic [7:0] b;
        logic       par;
        logic       stp;
    } frm_t;

    rec_t pq[$];
    frm_t exp_q[$];

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle: log every delivered frame and busy cycles.
    always @(negedge clk) begin
        if (rdsig) begin
            rec_t r;
            r.c = cyc; r.d = dataout; r.de = dataerror; r.fe = frameerror;
            r.d_o = dataout_o; r.de_o = dataerror_o; r.fe_o = frameerror_o;
            pq.push_back(r);
        end
        if (rdsig_o) pulses_odd++;
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Parity error rule: total ones over data+parity must be even (mode 0)
    // or odd (mode 1).
    function automatic int exp_de(input logic [7:0] b, input logic par, input logic mode);
        return (((($countones(b) + int'(par)) % 2) != int'(mode)) ? 1 : 0);
    endfunction

    function automatic logic even_par(input logic [7:0] b);
        return ($countones(b) % 2) != 0;
    endfunction

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par,
                              input logic stp, input int stop_len);
        drive(1'b0, 16);
        for (int i = 0; i < 8; i++) drive(b[i], 16);
        drive(par, 16);
        stop_edge = cyc;
        drive(stp, stop_len);
    endtask

    task automatic check_frame(input string tag, input frm_t f);
        rec_t r;
        checks++;
        assert (pq.size() > 0) else begin
            failures++;
            $error("FAIL %s_pulse observed=0 expected=1", tag);
        end
        if (pq.size() > 0) begin
            r = pq.pop_front();
            check({tag, "_data"},    int'(r.d),    int'(f.b));
            check({tag, "_derr"},    int'(r.de),   exp_de(f.b, f.par, 1'b0));
            check({tag, "_ferr"},    int'(r.fe),   int'(!f.stp));
            check({tag, "_data_o"},  int'(r.d_o),  int'(f.b));
            check({tag, "_derr_o"},  int'(r.de_o), exp_de(f.b, f.par, 1'b1));
            check({tag, "_ferr_o"},  int'(r.fe_o), int'(!f.stp));
        end
    endtask

    initial begin
        frm_t f;
        int   gap;

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dataout",    int'(dataout),    0);
        check("rst_rdsig",      int'(rdsig),      0);
        check("rst_dataerror",  int'(dataerror),  0);
        check("rst_frameerror", int'(frameerror), 0);
        check("rst_busy",       int'(busy),       0);
        check("rst_busy_o",     int'(busy_o),     0);
        rst = 1'b0;
        drive(1'b1, 20);

        // 0x55, correct even parity, with stop-edge latency
        f = '{8'h55, 1'b0, 1'b1};
        send_frame(f.b, f.par, f.stp, 16);
        n_exp++;
        drive(1'b1, 10);
        check("f55_count", pq.size(), 1);
        if (pq.size() > 0) begin
            checks++;
            assert ((pq[0].c - stop_edge) >= 10 && (pq[0].c - stop_edge) <= 12) else begin
                failures++;
                $error("FAIL f55_latency observed=%0d expected=11+/-1", pq[0].c - stop_edge);
            end
        end
        check_frame("f55", f);

        // 0xA3 with parity bit 1: wrong for even, right for odd
        f = '{8'hA3, 1'b1, 1'b1};
        send_frame(f.b, f.par, f.stp, 16);
        n_exp++;
        drive(1'b1, 10);
        check("fA3_count", pq.size(), 1);
        check_frame("fA3", f);

        // 5-cycle glitch on an idle line
        busy_cnt = 0;
        drive(1'b0, 5);
        drive(1'b1, 40);
        check("glitch_pulses", pq.size(), 0);
        checks++;
        assert (busy_cnt >= 1 && busy_cnt <= 10) else begin
            failures++;
            $error("FAIL glitch_busy_cycles observed=%0d expected=1..10", busy_cnt);
        end
        check("glitch_busy_end", int'(busy), 0);
        check("glitch_hold_data", int'(dataout), 'hA3);
        check("glitch_hold_derr", int'(dataerror), 1);

        // 0x00 with low stop bit, then line held low (break)
        f = '{8'h00, 1'b0, 1'b0};
        send_frame(f.b, f.par, f.stp, 16 + 40);
        n_exp++;
        check("break_busy_low", int'(busy), 1);
        check("break_count_low", pq.size(), 1);
        drive(1'b1, 6);
        check("break_busy_high", int'(busy), 0);
        drive(1'b1, 30);
        check("break_count", pq.size(), 1);
        check_frame("break", f);

        // Back-to-back 0x12, 0x34
        send_frame(8'h12, even_par(8'h12), 1'b1, 16);
        send_frame(8'h34, even_par(8'h34), 1'b1, 16);
        n_exp += 2;
        drive(1'b1, 10);
        check("b2b_count", pq.size(), 2);
        if (pq.size() >= 2) check("b2b_spacing", pq[1].c - pq[0].c, 176);
        f = '{8'h12, even_par(8'h12), 1'b1};
        check_frame("b2b_12", f);
        f = '{8'h34, even_par(8'h34), 1'b1};
        check_frame("b2b_34", f);

        // Reset during data bit 4
        f = '{8'h5A, even_par(8'h5A), 1'b1};
        drive(1'b0, 16);
        for (int i = 0; i < 4; i++) drive(f.b[i], 16);
        drive(f.b[4], 8);
        rst = 1'b1;
        #1;
        check("mid_rst_dataout", int'(dataout),    0);
        check("mid_rst_rdsig",   int'(rdsig),      0);
        check("mid_rst_derr",    int'(dataerror),  0);
        check("mid_rst_ferr",    int'(frameerror), 0);
        check("mid_rst_busy",    int'(busy),       0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 200);
        check("mid_rst_pulses", pq.size(), 0);
        f = '{8'hC7, even_par(8'hC7), 1'b1};
        send_frame(f.b, f.par, f.stp, 16);
        n_exp++;
        drive(1'b1, 10);
        check_frame("after_rst_C7", f);

        // Line already low when reset releases: taken as a start bit
        rst = 1'b1;
        rx  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        f = '{8'h9C, even_par(8'h9C), 1'b1};
        send_frame(f.b, f.par, f.stp, 16);
        n_exp++;
        drive(1'b1, 10);
        check_frame("rx_low_rst", f);

        // Random frames with random parity and random idle gaps
        for (int k = 0; k < 8; k++) begin
            f.b   = 8'($urandom_range(0, 255));
            f.par = 1'($urandom_range(0, 1));
            f.stp = 1'b1;
            exp_q.push_back(f);
            send_frame(f.b, f.par, f.stp, 16);
            n_exp++;
            gap = int'($urandom_range(0, 20));
            drive(1'b1, gap);
        end
        drive(1'b1, 20);
        check("rand_count", pq.size(), 8);
        while (exp_q.size() > 0) begin
            f = exp_q.pop_front();
            check_frame("rand", f);
        end

        check("odd_pulse_total", pulses_odd, n_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
